// File: rtl/mmio_out_port.sv
`default_nettype none
// ============================================================================
// Module      : mmio_out_port
// Description : Store-snooping output port with a small FIFO drain interface
//               and a one-shot pass/fail verdict on the first captured value.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_out_port #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] PORT_ADDR = 8'hFF,
    parameter logic [WIDTH-1:0] EXPECTED  = 8'h0D,
    parameter int               DEPTH     = 4,
    parameter int               LVLBITS   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memwrite,
    input  logic [WIDTH-1:0]   adr,
    input  logic [WIDTH-1:0]   writedata,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [LVLBITS-1:0] level,
    output logic               overflow,
    output logic [WIDTH-1:0]   wr_count,
    output logic               first_done,
    output logic               pass,
    output logic               fail
);

    localparam int               c_PTRW  = $clog2(DEPTH);
    localparam logic [LVLBITS-1:0] c_FULL = LVLBITS'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVLBITS-1:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [WIDTH-1:0]     wr_count_q, wr_count_d;
    logic                 first_done_q, first_done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic w_hit, w_empty, w_full, w_pop, w_push;

    assign w_hit   = memwrite && (adr == PORT_ADDR);
    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == c_FULL);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    assign w_push  = w_hit && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        wr_count_d   = wr_count_q;
        state_d      = state_q;
        first_done_d = first_done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTRW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTRW'(1);
        end
        if (w_push && !w_pop) begin
            level_d = level_q + LVLBITS'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - LVLBITS'(1);
        end

        if (w_hit && !w_push) begin
            overflow_d = 1'b1;
        end
        if (w_hit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (w_hit) begin
                    state_d      = ST_DONE;
                    first_done_d = 1'b1;
                    pass_d       = (writedata == EXPECTED);
                    fail_d       = (writedata != EXPECTED);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            wr_count_q   <= '0;
            first_done_q <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            wr_count_q   <= wr_count_d;
            first_done_q <= first_done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    // Storage needs no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= writedata;
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? '0 : mem_q[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign wr_count   = wr_count_q;
    assign first_done = first_done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_out_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_out_port
// Description : Directed self-checking bench for mmio_out_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_out_port;

    logic       clk;
    logic       reset;
    logic       memwrite;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] wr_count;
    logic       first_done;
    logic       pass;
    logic       fail;

    int total;
    int bad;

    mmio_out_port #(
        .WIDTH     (8),
        .PORT_ADDR (8'hFF),
        .EXPECTED  (8'h0D),
        .DEPTH     (4),
        .LVLBITS   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .wr_count   (wr_count),
        .first_done (first_done),
        .pass       (pass),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_data"},  {24'd0, out_data},  32'd0);
        check({tag, "_level"}, {29'd0, level},     32'd0);
        check({tag, "_ovf"},   {31'd0, overflow},  32'd0);
        check({tag, "_wrcnt"}, {24'd0, wr_count},  32'd0);
        check({tag, "_fdone"}, {31'd0, first_done},32'd0);
        check({tag, "_pass"},  {31'd0, pass},      32'd0);
        check({tag, "_fail"},  {31'd0, fail},      32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        memwrite  = 1'b0;
        adr       = 8'h00;
        writedata = 8'h00;
        out_ready = 1'b0;

        // Reset state
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst0");
        tick();
        reset = 1'b1;

        // Single matching store
        store(8'hFF, 8'h0D);
        check("t1_valid", {31'd0, out_valid},  32'd1);
        check("t1_data",  {24'd0, out_data},   32'h0D);
        check("t1_level", {29'd0, level},      32'd1);
        check("t1_wrcnt", {24'd0, wr_count},   32'd1);
        check("t1_fdone", {31'd0, first_done}, 32'd1);
        check("t1_pass",  {31'd0, pass},       32'd1);
        check("t1_fail",  {31'd0, fail},       32'd0);

        // Non-matching address, then wrong first value
        do_reset();
        store(8'hFE, 8'h55);
        check("t2_level", {29'd0, level},      32'd0);
        check("t2_wrcnt", {24'd0, wr_count},   32'd0);
        check("t2_fdone", {31'd0, first_done}, 32'd0);
        store(8'hFF, 8'h07);
        check("t2_fail",  {31'd0, fail},       32'd1);
        check("t2_pass",  {31'd0, pass},       32'd0);
        store(8'hFF, 8'h0D);
        check("t2_pass2", {31'd0, pass},       32'd0);
        check("t2_fail2", {31'd0, fail},       32'd1);
        check("t2_wrcnt2",{24'd0, wr_count},   32'd2);
        check("t2_level2",{29'd0, level},      32'd2);

        // Overflow on fifth hit, then in-order drain
        do_reset();
        for (int i = 1; i <= 4; i++) store(8'hFF, 8'(i));
        check("t3_level4", {29'd0, level},    32'd4);
        check("t3_ovf0",   {31'd0, overflow}, 32'd0);
        store(8'hFF, 8'h05);
        check("t3_level",  {29'd0, level},    32'd4);
        check("t3_ovf",    {31'd0, overflow}, 32'd1);
        check("t3_wrcnt",  {24'd0, wr_count}, 32'd5);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_dvalid", {31'd0, out_valid}, 32'd1);
            check("t3_ddata",  {24'd0, out_data},  32'(i));
            tick();
        end
        check("t3_empty",  {31'd0, out_valid}, 32'd0);
        check("t3_edata",  {24'd0, out_data},  32'd0);
        check("t3_ovfst",  {31'd0, overflow},  32'd1);
        out_ready = 1'b0;

        // Push and pop together while full
        do_reset();
        for (int i = 1; i <= 4; i++) store(8'hFF, 8'(i));
        out_ready = 1'b1;
        store(8'hFF, 8'hAA);
        check("t4_ovf",   {31'd0, overflow}, 32'd0);
        check("t4_level", {29'd0, level},    32'd4);
        exp_q[0] = 8'h02;
        exp_q[1] = 8'h03;
        exp_q[2] = 8'h04;
        exp_q[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            check("t4_ddata", {24'd0, out_data}, {24'd0, exp_q[i]});
            tick();
        end
        check("t4_empty", {31'd0, out_valid}, 32'd0);
        check("t4_ovf2",  {31'd0, overflow},  32'd0);

        // Streaming at one hit per cycle across pointer wrap
        do_reset();
        out_ready = 1'b1;
        memwrite  = 1'b1;
        adr       = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            writedata = 8'h10 + 8'(i);
            tick();
            check("t5_level", {29'd0, level},    32'd1);
            check("t5_data",  {24'd0, out_data}, 32'h10 + 32'(i));
        end
        memwrite = 1'b0;
        tick();
        check("t5_empty", {31'd0, out_valid}, 32'd0);
        check("t5_wrcnt", {24'd0, wr_count},  32'd10);
        check("t5_fail",  {31'd0, fail},      32'd1);

        // wr_count saturation (out_ready keeps FIFO from overflowing)
        memwrite = 1'b1;
        for (int i = 0; i < 250; i++) begin
            writedata = 8'(i);
            tick();
        end
        memwrite = 1'b0;
        tick();
        check("t5_sat",    {24'd0, wr_count}, 32'hFF);
        check("t5_satovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset mid-drain
        do_reset();
        store(8'hFF, 8'h0D);
        store(8'hFF, 8'h21);
        store(8'hFF, 8'h22);
        store(8'hFF, 8'h23);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_level", {29'd0, level}, 32'd3);
        check("t6_pass",  {31'd0, pass},  32'd1);
        check("t6_head",  {24'd0, out_data}, 32'h21);
        #2;
        reset = 1'b0;
        #1;
        check_zero("t6_arst");
        tick();
        reset = 1'b1;
        store(8'hFF, 8'h0D);
        check("t6_pass2", {31'd0, pass},     32'd1);
        check("t6_lvl2",  {29'd0, level},    32'd1);
        check("t6_data2", {24'd0, out_data}, 32'h0D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
